data_mem_responder: RTL and testbench

//  Word-addressed data memory that responds to the MEM-stage load/store port of the pipelined CPU.

---
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Word-addressed data memory for the MEM-stage load/store port.
//             Adds WAIT_CYCLES wait states and returns data as a one-cycle
//             pulse. Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned
//             accesses instead of rounding them down to the word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_stall
);

  localparam int         c_idxW     = $clog2(DEPTH);
  localparam logic [3:0] c_waitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_cnt;
  logic [3:0]          w_nextCnt;
  logic                w_latch;

  logic                r_we;
  logic [c_idxW+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_rdata;

  logic                w_fromIdle;
  logic                w_accWe;
  logic [c_idxW+1:0]   w_accAddr;
  logic [c_idxW-1:0]   w_accIdx;
  logic [31:0]         w_accWdata;
  logic [3:0]          w_accBe;
  logic                w_enterResp;
  logic                w_misalign;
  logic                w_wrEn;
  logic                w_unusedAddrHigh;

  logic [31:0]         mem [DEPTH];

  // Upper address bits only select aliases of the same word.
  assign w_unusedAddrHigh = ^req_addr[ADDR_W-1:c_idxW+2];

  // With zero wait states the access happens on the accept edge itself,
  // so the live request is used instead of the (not yet loaded) latch.
  assign w_fromIdle  = (r_state == S_IDLE);
  assign w_accWe     = w_fromIdle ? req_we                  : r_we;
  assign w_accAddr   = w_fromIdle ? req_addr[c_idxW+1:0]    : r_addr;
  assign w_accWdata  = w_fromIdle ? req_wdata               : r_wdata;
  assign w_accBe     = w_fromIdle ? req_be                  : r_be;
  assign w_accIdx    = w_accAddr[c_idxW+1:2];
  assign w_enterResp = (w_nextState == S_RESP);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = (w_accAddr[1:0] != 2'b00);
  assign resp_err   = r_err;
`else
  logic w_unusedAddrLow;
  assign w_unusedAddrLow = ^w_accAddr[1:0];
  assign w_misalign      = 1'b0;
  assign resp_err        = 1'b0;
`endif

  // A write racing an asserted reset must not land in the array.
  assign w_wrEn = w_enterResp & w_accWe & ~w_misalign & ~reset;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_nextState = S_RESP;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = c_waitLoad;
          end
        end
      end
      S_WAIT: begin
        w_nextCnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_latch) begin
        r_we    <= req_we;
        r_addr  <= req_addr[c_idxW+1:0];
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      r_rdata <= (w_enterResp && !w_accWe && !w_misalign) ? mem[w_accIdx] : 32'd0;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enterResp && w_misalign;
    end
  end
`endif

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wrEn && w_accBe[i]) begin
        mem[w_accIdx][8*i +: 8] <= w_accWdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign mem_stall  = ((r_state == S_IDLE) && req_valid) || (r_state == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed self-checking bench for data_mem_responder (WAIT_CYCLES=2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;

  int errCnt = 0;
  int chkCnt = 0;

  data_mem_responder #(
    .DEPTH       (256),
    .ADDR_W      (32),
    .WAIT_CYCLES (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_stall  (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request from IDLE (called at posedge+1), then scrambles the
  // inputs so only the latched request can complete correctly.
  task automatic doReq(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] expData, input logic expErr);
    logic got;
    int   lat;
    int   stalls;
    got    = 1'b0;
    lat    = 0;
    stalls = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, ".ready"}, 32'(req_ready), 32'd1);
      if (resp_valid) begin
        got = 1'b1;
        check({tag, ".rdata"}, resp_rdata, expData);
        check({tag, ".err"}, 32'(resp_err), 32'(expErr));
        check({tag, ".respStall"}, 32'(mem_stall), 32'd0);
      end else begin
        lat++;
        if (mem_stall) stalls++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'h0000_0FFC;
      req_wdata = 32'hA5A5_A5A5;
      req_be    = 4'hF;
    end
    if (!got) check({tag, ".timeout"}, 32'd0, 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".stalls"}, 32'(stalls), 32'd3);
  endtask

  initial begin
    logic [11:0] stallV;
    logic [11:0] respV;
    logic [31:0] lastRd;
    int          strayResp;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;

    #12;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.respValid", 32'(resp_valid), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", 32'(resp_err), 32'd0);
    check("rst.stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full-word store then load
    doReq("st1", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    doReq("ld1", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte-lane stores
    doReq("st2", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'd0, 1'b0);
    doReq("ld2", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);
    doReq("stBe0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
    doReq("ldBe0", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEAA, 1'b0);
    doReq("stBeA", 1'b1, 32'h10, 32'h11223344, 4'hA, 32'd0, 1'b0);
    doReq("ldBeA", 1'b0, 32'h10, 32'd0, 4'h0, 32'h11AD33AA, 1'b0);

    // Continuous loads: stall 3 cycles, response every 4th cycle
    stallV    = '0;
    respV     = '0;
    lastRd    = '0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      stallV[k] = mem_stall;
      respV[k]  = resp_valid;
      if (resp_valid) lastRd = resp_rdata;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("cont.stallPattern", 32'(stallV), 32'h777);
    check("cont.respPattern", 32'(respV), 32'h888);
    check("cont.rdata", lastRd, 32'h11AD33AA);
    @(posedge clk);
    #1;

    // Reset during WAIT discards the store
    doReq("stPrior", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstWait.inWait", 32'(req_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rstWait.asyncReady", 32'(req_ready), 32'd1);
    check("rstWait.asyncStall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    strayResp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) strayResp++;
    end
    check("rstWait.noResp", 32'(strayResp), 32'd0);
    @(posedge clk);
    #1;
    doReq("ldAfterRst", 1'b0, 32'h20, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);
    doReq("ldKeep", 1'b0, 32'h10, 32'd0, 4'h0, 32'h11AD33AA, 1'b0);

    // Address wrap modulo 4*DEPTH bytes
    doReq("stWrap", 1'b1, 32'h400, 32'h00000055, 4'hF, 32'd0, 1'b0);
    doReq("ldWrap0", 1'b0, 32'h000, 32'd0, 4'h0, 32'h00000055, 1'b0);
    doReq("ldWrapHi", 1'b0, 32'h8000_0800, 32'd0, 4'h0, 32'h00000055, 1'b0);

    // Misaligned load
`ifdef DMEM_MISALIGN_CHECK_EN
    doReq("ldMis", 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1);
`else
    doReq("ldMis", 1'b0, 32'h13, 32'd0, 4'h0, 32'h11AD33AA, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

`default_nettype wire
